// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial 4-bit ALU.
// Holds the operation encoding, the datapath width, the bit-counter width
// and the FSM state type/constants used by serial_alu4 and alu_slice.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = $clog2(ALU_W);

  // Operation select as presented on the aluctr port.
  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage : alu_pkg

// File: rtl/alu_slice.sv
// One-bit ALU slice, purely combinational.
// Ports:
//   a, b    - operand bits
//   cin     - carry into this bit
//   aluctr  - operation select (alu_op_e)
//   d       - result bit
//   e       - carry out of this bit (0 for AND/OR)
module alu_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e aluctr,
  output logic    d,
  output logic    e
);

  logic b_eff;

  // Subtraction is addition of the inverted operand; the +1 comes from cin.
  assign b_eff = (aluctr == ALU_SUB) ? ~b : b;

  always_comb begin
    d = 1'b0;
    e = 1'b0;
    case (aluctr)
      ALU_AND: d = a & b;
      ALU_OR:  d = a | b;
      ALU_ADD,
      ALU_SUB: begin
        d = a ^ b_eff ^ cin;
        e = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: begin
        d = 1'b0;
        e = 1'b0;
      end
    endcase
  end

endmodule : alu_slice

// File: rtl/serial_alu4.sv
// Bit-serial 4-bit ALU (AND/OR/ADD/SUB), one operand bit per clock, LSB first.
// An accepted start latches a, b, c and aluctr; four SHIFT cycles follow,
// then a one-cycle DONE state publishes d/e and pulses done.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - begin an operation (accepted in IDLE or DONE)
//   a, b    - operands; c - carry-in for bit 0; aluctr - operation select
//   busy    - high while shifting
//   done    - one-cycle pulse when d/e carry a new result
//   d, e    - last result and its carry-out
//   z       - (only with SERIAL_ALU_ZERO_FLAG_EN defined) 1 iff last d == 0
module serial_alu4
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             c,
  input  logic [1:0]       aluctr,
  output logic             busy,
  output logic             done,
  output logic [ALU_W-1:0] d,
  output logic             e
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             z
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [ALU_W-1:0] res_q, res_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;
  logic [ALU_W-1:0] d_q, d_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic             z_q, z_d;
`endif

  logic             slice_d, slice_e;
  logic [ALU_W-1:0] res_next;

  // Single shared slice; the counter picks which latched bit it sees.
  alu_slice u_slice (
    .a      (a_q[cnt_q]),
    .b      (b_q[cnt_q]),
    .cin    (carry_q),
    .aluctr (op_q),
    .d      (slice_d),
    .e      (slice_e)
  );

  // Result bits enter at the MSB and move down, so bit 0 lands at LSB after 4 shifts.
  assign res_next = {slice_d, res_q[ALU_W-1:1]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    d_d     = d_q;
    e_d     = e_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    z_d     = z_q;
`endif

    case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_e'(aluctr);
          carry_d = c;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        res_d   = res_next;
        carry_d = slice_e;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ALU_W - 1)) begin
          // Last bit: publish result and carry on the same edge.
          d_d     = res_next;
          e_d     = slice_e;
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
          z_d     = (res_next == '0);
`endif
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_AND;
      d_q     <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      d_q     <= d_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      z_q     <= z_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign e    = e_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  assign z    = z_q;
`endif

endmodule : serial_alu4
